// File: rtl/performance_counter_collector_if.sv
// rtl/performance_counter_collector_if.sv - result-write port bundle between collector and result writer
interface performance_counter_collector_if #(
  parameter int CH      = 4,
  parameter int DATA_WD = 32,
  parameter int REQ_WD  = 12
);
  localparam int CH_W = $clog2(CH);

  logic               o_wr_valid;
  logic [CH_W-1:0]    o_wr_ch;
  logic [DATA_WD-1:0] o_wr_cnt;
  logic [REQ_WD-1:0]  o_wr_req_cnt;
  logic               i_wr_ack;

  modport master (
    output o_wr_valid,
    output o_wr_ch,
    output o_wr_cnt,
    output o_wr_req_cnt,
    input  i_wr_ack
  );

  modport slave (
    input  o_wr_valid,
    input  o_wr_ch,
    input  o_wr_cnt,
    input  o_wr_req_cnt,
    output i_wr_ack
  );
endinterface

// File: rtl/performance_counter_collector.sv
// rtl/performance_counter_collector.sv - round-robin drain of per-channel counter snapshots onto one write port
module performance_counter_collector #(
  parameter int CH       = 4,
  parameter int DATA_WD  = 32,
  parameter int REQ_WD   = 12,
  parameter int DRAIN_TO = 255
) (
  input  logic                  i_bus_clk,
  input  logic                  i_bus_rst_n,
  input  logic                  i_enable,
  input  logic [CH-1:0]         i_ready,
  input  logic [CH*DATA_WD-1:0] i_cnt,
  input  logic [CH*REQ_WD-1:0]  i_req_cnt,
  output logic [CH-1:0]         o_cp_cmplt,
  output logic                  o_busy,
  output logic [15:0]           o_snap_cnt,
  output logic                  o_drain_err,
  performance_counter_collector_if.master wr_if
);
  localparam int CH_W  = $clog2(CH);
  localparam int TMR_W = $clog2(DRAIN_TO + 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CMPLT, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    ptr_q, ptr_d;
  logic [CH_W-1:0]    grant_q, grant_d;
  logic               wr_valid_q, wr_valid_d;
  logic [CH_W-1:0]    wr_ch_q, wr_ch_d;
  logic [DATA_WD-1:0] wr_cnt_q, wr_cnt_d;
  logic [REQ_WD-1:0]  wr_req_cnt_q, wr_req_cnt_d;
  logic [CH-1:0]      cp_cmplt_q, cp_cmplt_d;
  logic [15:0]        snap_cnt_q, snap_cnt_d;
  logic               drain_err_q, drain_err_d;
  logic               busy_q, busy_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic               sel_found;
  logic [CH_W-1:0]    sel_idx;
  logic [CH_W-1:0]    grant_nxt;
  logic               drain_expired;

  assign grant_nxt     = (grant_q == CH_W'(CH - 1)) ? '0 : grant_q + 1'b1;
  assign drain_expired = (timer_q == TMR_W'(DRAIN_TO - 1));

  // Pick the first ready channel at or above the RR pointer, wrapping; scan high-to-low so the nearest wins
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % CH;
      if (i_ready[CH_W'(idx)]) begin
        sel_found = 1'b1;
        sel_idx   = CH_W'(idx);
      end
    end
  end

  // All state and output registers, cleared synchronously
  always_ff @(posedge i_bus_clk) begin
    if (!i_bus_rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      wr_valid_q   <= 1'b0;
      wr_ch_q      <= '0;
      wr_cnt_q     <= '0;
      wr_req_cnt_q <= '0;
      cp_cmplt_q   <= '0;
      snap_cnt_q   <= '0;
      drain_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      wr_valid_q   <= wr_valid_d;
      wr_ch_q      <= wr_ch_d;
      wr_cnt_q     <= wr_cnt_d;
      wr_req_cnt_q <= wr_req_cnt_d;
      cp_cmplt_q   <= cp_cmplt_d;
      snap_cnt_q   <= snap_cnt_d;
      drain_err_q  <= drain_err_d;
      busy_q       <= busy_d;
      timer_q      <= timer_d;
    end
  end

  // Next state: grant, wait for ack, pulse copy-complete, then wait for the granted ready to fall
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_enable && sel_found) state_d = S_WRITE;
      S_WRITE: if (wr_if.i_wr_ack) state_d = S_CMPLT;
      S_CMPLT: state_d = S_DRAIN;
      S_DRAIN: if (!i_ready[grant_q] || drain_expired) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs and datapath: snapshot capture at grant, pulse on ack, pointer advance on drain exit
  always_comb begin
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    wr_valid_d   = wr_valid_q;
    wr_ch_d      = wr_ch_q;
    wr_cnt_d     = wr_cnt_q;
    wr_req_cnt_d = wr_req_cnt_q;
    cp_cmplt_d   = '0;
    snap_cnt_d   = snap_cnt_q;
    drain_err_d  = drain_err_q;
    timer_d      = timer_q;
    case (state_q)
      S_IDLE: begin
        if (i_enable && sel_found) begin
          grant_d      = sel_idx;
          wr_ch_d      = sel_idx;
          wr_valid_d   = 1'b1;
          wr_cnt_d     = i_cnt[int'(sel_idx) * DATA_WD +: DATA_WD];
          wr_req_cnt_d = i_req_cnt[int'(sel_idx) * REQ_WD +: REQ_WD];
        end
      end
      S_WRITE: begin
        if (wr_if.i_wr_ack) begin
          wr_valid_d          = 1'b0;
          cp_cmplt_d[grant_q] = 1'b1;
          snap_cnt_d          = snap_cnt_q + 16'd1;
        end
      end
      S_CMPLT: begin
        timer_d = '0;
      end
      S_DRAIN: begin
        if (!i_ready[grant_q]) begin
          ptr_d = grant_nxt;
        end else if (drain_expired) begin
          drain_err_d = 1'b1;
          ptr_d       = grant_nxt;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign o_cp_cmplt         = cp_cmplt_q;
  assign o_busy             = busy_q;
  assign o_snap_cnt         = snap_cnt_q;
  assign o_drain_err        = drain_err_q;
  assign wr_if.o_wr_valid   = wr_valid_q;
  assign wr_if.o_wr_ch      = wr_ch_q;
  assign wr_if.o_wr_cnt     = wr_cnt_q;
  assign wr_if.o_wr_req_cnt = wr_req_cnt_q;
endmodule
